// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mem_port_arbiter_if                                              |
// | Brief   : Requester, Data_Memory and status signals of mem_port_arbiter.   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  // Port 0 (dcache)
  logic              m0_enable_i;
  logic              m0_write_i;
  logic [ADDR_W-1:0] m0_addr_i;
  logic [LINE_W-1:0] m0_data_i;
  logic              m0_ack_o;
  logic [LINE_W-1:0] m0_data_o;
  // Port 1 (icache / prefetcher)
  logic              m1_enable_i;
  logic              m1_write_i;
  logic [ADDR_W-1:0] m1_addr_i;
  logic [LINE_W-1:0] m1_data_i;
  logic              m1_ack_o;
  logic [LINE_W-1:0] m1_data_o;
  // Data_Memory side
  logic              mem_enable_o;
  logic              mem_write_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [LINE_W-1:0] mem_data_o;
  logic              mem_ack_i;
  logic [LINE_W-1:0] mem_data_i;
  // Status
  logic              busy_o;
  logic              owner_o;
  logic              err_timeout_o;

  modport slave (
    input  m0_enable_i, m0_write_i, m0_addr_i, m0_data_i,
    output m0_ack_o, m0_data_o,
    input  m1_enable_i, m1_write_i, m1_addr_i, m1_data_i,
    output m1_ack_o, m1_data_o,
    output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
    input  mem_ack_i, mem_data_i,
    output busy_o, owner_o, err_timeout_o
  );

  modport master (
    output m0_enable_i, m0_write_i, m0_addr_i, m0_data_i,
    input  m0_ack_o, m0_data_o,
    output m1_enable_i, m1_write_i, m1_addr_i, m1_data_i,
    input  m1_ack_o, m1_data_o,
    input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
    output mem_ack_i, mem_data_i,
    input  busy_o, owner_o, err_timeout_o
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mem_port_arbiter                                                 |
// | Brief   : Two-requester single-owner arbiter for the 256-bit Data_Memory   |
// |           port, fixed or round-robin priority. Optional watchdog enabled   |
// |           by defining MEM_ARB_TIMEOUT_EN.                                  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int LINE_W         = 256,
  parameter int RR_EN_DEFAULT  = 1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_owner_q, last_owner_d;
  logic              busy;
  logic              tie_grant;
  logic              timeout_hit;
  logic              owner_enable;
  logic              owner_write;
  logic [ADDR_W-1:0] owner_addr;
  logic [LINE_W-1:0] owner_data;

  assign busy = (state_q == BUSY);

  // Round-robin hands a tie to whichever port did not complete last.
  assign tie_grant = (RR_EN_DEFAULT != 0) ? ~last_owner_q : 1'b0;

  always_comb begin
    owner_enable = bus.m0_enable_i;
    owner_write  = bus.m0_write_i;
    owner_addr   = bus.m0_addr_i;
    owner_data   = bus.m0_data_i;
    if (owner_q) begin
      owner_enable = bus.m1_enable_i;
      owner_write  = bus.m1_write_i;
      owner_addr   = bus.m1_addr_i;
      owner_data   = bus.m1_data_i;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_timeout_q, err_timeout_d;

  // Count is zero in the first BUSY cycle, so the limit is hit on the last allowed one.
  assign timeout_hit = busy && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d         = '0;
    err_timeout_d = err_timeout_q;
    if (busy) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (busy && !bus.mem_ack_i && owner_enable && timeout_hit) begin
      err_timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q         <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign bus.err_timeout_o = err_timeout_q;
`else
  assign timeout_hit       = 1'b0;
  assign bus.err_timeout_o = 1'b0;

  // Keeps TIMEOUT_CYCLES referenced when the watchdog is compiled out.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
  end
`endif

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    case (state_q)
      IDLE: begin
        if (bus.m0_enable_i && bus.m1_enable_i) begin
          owner_d = tie_grant;
          state_d = BUSY;
        end else if (bus.m0_enable_i) begin
          owner_d = 1'b0;
          state_d = BUSY;
        end else if (bus.m1_enable_i) begin
          owner_d = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (bus.mem_ack_i) begin
          last_owner_d = owner_q;
          state_d      = IDLE;
        end else if (!owner_enable) begin
          // Abort: the owner withdrew, so round-robin history is left alone.
          state_d = IDLE;
        end else if (timeout_hit) begin
          last_owner_d = owner_q;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
    end
  end

  assign bus.mem_enable_o = busy & owner_enable;
  assign bus.mem_write_o  = busy & owner_write;
  assign bus.mem_addr_o   = busy ? owner_addr : '0;
  assign bus.mem_data_o   = busy ? owner_data : '0;

  assign bus.m0_ack_o  = bus.mem_ack_i & busy & ~owner_q;
  assign bus.m1_ack_o  = bus.mem_ack_i & busy & owner_q;
  assign bus.m0_data_o = bus.mem_data_i;
  assign bus.m1_data_o = bus.mem_data_i;

  assign bus.busy_o  = busy;
  assign bus.owner_o = owner_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_mem_port_arbiter                                              |
// | Brief   : Directed self-checking bench; round-robin and fixed-priority DUTs.|
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_mem_port_arbiter;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;
  localparam logic [LINE_W-1:0] LINE0 =
    256'h0000_1111_2222_3333_4444_5555_6666_7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF;
  localparam logic [LINE_W-1:0] WDATA0 = {8{32'hA5A5_0200}};
  localparam logic [LINE_W-1:0] WDATA1 = {8{32'h5A5A_03C0}};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus_rr ();
  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus_fx ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .RR_EN_DEFAULT(1), .TIMEOUT_CYCLES(8))
    dut_rr (.clk_i(clk), .rst_i(rst), .bus(bus_rr));
  mem_port_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .RR_EN_DEFAULT(0), .TIMEOUT_CYCLES(8))
    dut_fx (.clk_i(clk), .rst_i(rst), .bus(bus_fx));

  task automatic idle_inputs();
    bus_rr.m0_enable_i = 1'b0; bus_rr.m0_write_i = 1'b0; bus_rr.m0_addr_i = '0; bus_rr.m0_data_i = '0;
    bus_rr.m1_enable_i = 1'b0; bus_rr.m1_write_i = 1'b0; bus_rr.m1_addr_i = '0; bus_rr.m1_data_i = '0;
    bus_rr.mem_ack_i = 1'b0;   bus_rr.mem_data_i = '0;
    bus_fx.m0_enable_i = 1'b0; bus_fx.m0_write_i = 1'b0; bus_fx.m0_addr_i = '0; bus_fx.m0_data_i = '0;
    bus_fx.m1_enable_i = 1'b0; bus_fx.m1_write_i = 1'b0; bus_fx.m1_addr_i = '0; bus_fx.m1_data_i = '0;
    bus_fx.mem_ack_i = 1'b0;   bus_fx.mem_data_i = '0;
  endtask

  // Leaves the caller 1 time unit after a rising edge with reset released.
  task automatic apply_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    #1;
    tests_run++;
    if ({bus_rr.busy_o, bus_rr.owner_o, bus_rr.mem_enable_o, bus_rr.mem_write_o, bus_rr.m0_ack_o,
         bus_rr.m1_ack_o, bus_rr.err_timeout_o} !== 7'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs_rr: got %b expected 0000000", {bus_rr.busy_o, bus_rr.owner_o,
               bus_rr.mem_enable_o, bus_rr.mem_write_o, bus_rr.m0_ack_o, bus_rr.m1_ack_o, bus_rr.err_timeout_o});
    end
    tests_run++;
    if ({bus_fx.busy_o, bus_fx.owner_o, bus_fx.mem_enable_o, bus_fx.mem_addr_o} !== 35'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs_fx: got %h expected 0", {bus_fx.busy_o, bus_fx.owner_o,
               bus_fx.mem_enable_o, bus_fx.mem_addr_o});
    end
    apply_reset();
  endtask

  task automatic test_single_read();
    apply_reset();
    bus_rr.m0_enable_i = 1'b1; bus_rr.m0_write_i = 1'b0; bus_rr.m0_addr_i = 32'h0000_0000;
    @(negedge clk);
    tests_run++;
    if (bus_rr.mem_enable_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL read_latency: mem_enable got %b expected 0", bus_rr.mem_enable_o);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (i == 9) begin bus_rr.mem_ack_i = 1'b1; bus_rr.mem_data_i = LINE0; end
      @(negedge clk);
      tests_run++;
      if ({bus_rr.mem_enable_o, bus_rr.m1_ack_o, bus_rr.m0_ack_o} !== {1'b1, 1'b0, (i == 9)}) begin
        tests_failed++;
        $display("FAIL read_cycle%0d: en/ack1/ack0 got %b expected %b", i,
                 {bus_rr.mem_enable_o, bus_rr.m1_ack_o, bus_rr.m0_ack_o}, {1'b1, 1'b0, (i == 9)});
      end
    end
    tests_run++;
    if (bus_rr.m0_data_o !== LINE0) begin
      tests_failed++;
      $display("FAIL read_data: got %h expected %h", bus_rr.m0_data_o, LINE0);
    end
    @(posedge clk); #1;
    bus_rr.m0_enable_i = 1'b0; bus_rr.mem_ack_i = 1'b0; bus_rr.mem_data_i = '0;
    @(negedge clk);
    tests_run++;
    if ({bus_rr.mem_enable_o, bus_rr.busy_o, bus_rr.m0_ack_o} !== 3'b000) begin
      tests_failed++;
      $display("FAIL read_release: en/busy/ack got %b expected 000",
               {bus_rr.mem_enable_o, bus_rr.busy_o, bus_rr.m0_ack_o});
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] order = 8'b1010_1010;
    int         left0 = 4;
    int         left1 = 4;
    logic       exp;
    apply_reset();
    bus_rr.m0_enable_i = 1'b1; bus_rr.m0_addr_i = 32'h0000_0100;
    bus_rr.m1_enable_i = 1'b1; bus_rr.m1_addr_i = 32'h0000_0180;
    @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      exp = order[k];
      @(negedge clk);
      tests_run++;
      if ({bus_rr.busy_o, bus_rr.owner_o, bus_rr.mem_addr_o} !==
          {1'b1, exp, (exp ? 32'h0000_0180 : 32'h0000_0100)}) begin
        tests_failed++;
        $display("FAIL rr_grant%0d: busy/owner/addr got %h expected owner %b", k,
                 {bus_rr.busy_o, bus_rr.owner_o, bus_rr.mem_addr_o}, exp);
      end
      bus_rr.mem_ack_i = 1'b1;
      #1;
      tests_run++;
      if ({bus_rr.m1_ack_o, bus_rr.m0_ack_o} !== (exp ? 2'b10 : 2'b01)) begin
        tests_failed++;
        $display("FAIL rr_ack%0d: ack1/ack0 got %b expected %b", k,
                 {bus_rr.m1_ack_o, bus_rr.m0_ack_o}, (exp ? 2'b10 : 2'b01));
      end
      @(posedge clk); #1;
      bus_rr.mem_ack_i = 1'b0;
      if (exp) begin left1--; if (left1 == 0) bus_rr.m1_enable_i = 1'b0; end
      else     begin left0--; if (left0 == 0) bus_rr.m0_enable_i = 1'b0; end
      @(negedge clk);
      tests_run++;
      if ({bus_rr.busy_o, bus_rr.mem_enable_o} !== 2'b00) begin
        tests_failed++;
        $display("FAIL rr_gap%0d: busy/en got %b expected 00", k, {bus_rr.busy_o, bus_rr.mem_enable_o});
      end
      @(posedge clk);
    end
  endtask

  task automatic test_fixed_priority();
    logic [7:0] order = 8'b1111_0000;
    int         left0 = 4;
    int         left1 = 4;
    logic       exp;
    apply_reset();
    bus_fx.m0_enable_i = 1'b1; bus_fx.m1_enable_i = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      exp = order[k];
      @(negedge clk);
      tests_run++;
      if ({bus_fx.busy_o, bus_fx.owner_o} !== {1'b1, exp}) begin
        tests_failed++;
        $display("FAIL fixed_grant%0d: busy/owner got %b expected %b", k,
                 {bus_fx.busy_o, bus_fx.owner_o}, {1'b1, exp});
      end
      bus_fx.mem_ack_i = 1'b1;
      @(posedge clk); #1;
      bus_fx.mem_ack_i = 1'b0;
      if (exp) begin left1--; if (left1 == 0) bus_fx.m1_enable_i = 1'b0; end
      else     begin left0--; if (left0 == 0) bus_fx.m0_enable_i = 1'b0; end
      @(posedge clk);
    end
  endtask

  task automatic test_pending_request();
    apply_reset();
    bus_rr.m0_enable_i = 1'b1; bus_rr.m0_write_i = 1'b1;
    bus_rr.m0_addr_i = 32'h0000_0200; bus_rr.m0_data_i = WDATA0;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) begin
        bus_rr.m1_enable_i = 1'b1; bus_rr.m1_write_i = 1'b0;
        bus_rr.m1_addr_i = 32'h0000_03C0; bus_rr.m1_data_i = WDATA1;
      end
      @(negedge clk);
      tests_run++;
      if ({bus_rr.busy_o, bus_rr.owner_o, bus_rr.mem_enable_o, bus_rr.mem_write_o,
           bus_rr.mem_addr_o, bus_rr.mem_data_o} !== {4'b1011, 32'h0000_0200, WDATA0}) begin
        tests_failed++;
        $display("FAIL pend_hold%0d: owner %b write %b addr %h expected owner 0 write 1 addr 00000200",
                 i, bus_rr.owner_o, bus_rr.mem_write_o, bus_rr.mem_addr_o);
      end
      @(posedge clk); #1;
    end
    bus_rr.mem_ack_i = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({bus_rr.m0_ack_o, bus_rr.m1_ack_o} !== 2'b10) begin
      tests_failed++;
      $display("FAIL pend_ack: ack0/ack1 got %b expected 10", {bus_rr.m0_ack_o, bus_rr.m1_ack_o});
    end
    @(posedge clk); #1;
    bus_rr.m0_enable_i = 1'b0; bus_rr.mem_ack_i = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({bus_rr.busy_o, bus_rr.mem_enable_o} !== 2'b00) begin
      tests_failed++;
      $display("FAIL pend_gap: busy/en got %b expected 00", {bus_rr.busy_o, bus_rr.mem_enable_o});
    end
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({bus_rr.busy_o, bus_rr.owner_o, bus_rr.mem_enable_o, bus_rr.mem_write_o, bus_rr.mem_addr_o}
        !== {4'b1110, 32'h0000_03C0}) begin
      tests_failed++;
      $display("FAIL pend_grant1: busy/owner/en/wr/addr got %h expected e000003c0",
               {bus_rr.busy_o, bus_rr.owner_o, bus_rr.mem_enable_o, bus_rr.mem_write_o, bus_rr.mem_addr_o});
    end
    bus_rr.mem_ack_i = 1'b1;
    @(posedge clk); #1;
    bus_rr.mem_ack_i = 1'b0; bus_rr.m1_enable_i = 1'b0;
  endtask

  task automatic test_abort();
    apply_reset();
    bus_rr.m0_enable_i = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus_rr.m0_enable_i = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({bus_rr.busy_o, bus_rr.mem_enable_o, bus_rr.m0_ack_o} !== 3'b100) begin
      tests_failed++;
      $display("FAIL abort_drop: busy/en/ack got %b expected 100",
               {bus_rr.busy_o, bus_rr.mem_enable_o, bus_rr.m0_ack_o});
    end
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({bus_rr.busy_o, bus_rr.m0_ack_o} !== 2'b00) begin
      tests_failed++;
      $display("FAIL abort_idle: busy/ack got %b expected 00", {bus_rr.busy_o, bus_rr.m0_ack_o});
    end
    bus_rr.mem_ack_i = 1'b1;
    #1;
    tests_run++;
    if ({bus_rr.m0_ack_o, bus_rr.m1_ack_o} !== 2'b00) begin
      tests_failed++;
      $display("FAIL idle_ack_ignored: ack0/ack1 got %b expected 00", {bus_rr.m0_ack_o, bus_rr.m1_ack_o});
    end
    bus_rr.mem_ack_i = 1'b0;
    @(posedge clk); #1;
    bus_rr.m0_enable_i = 1'b1; bus_rr.m1_enable_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({bus_rr.busy_o, bus_rr.owner_o} !== 2'b10) begin
      tests_failed++;
      $display("FAIL abort_history: busy/owner got %b expected 10", {bus_rr.busy_o, bus_rr.owner_o});
    end
    bus_rr.mem_ack_i = 1'b1;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic test_async_reset();
    apply_reset();
    bus_rr.m0_enable_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_rr.mem_ack_i = 1'b1;
    @(posedge clk); #1;
    bus_rr.mem_ack_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus_rr.mem_ack_i = 1'b1;
    #1;
    tests_run++;
    if ({bus_rr.busy_o, bus_rr.mem_enable_o, bus_rr.m0_ack_o} !== 3'b111) begin
      tests_failed++;
      $display("FAIL arst_before: busy/en/ack got %b expected 111",
               {bus_rr.busy_o, bus_rr.mem_enable_o, bus_rr.m0_ack_o});
    end
    #1 rst = 1'b1;
    #1;
    tests_run++;
    if ({bus_rr.busy_o, bus_rr.mem_enable_o, bus_rr.m0_ack_o, bus_rr.owner_o} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL arst_drop: busy/en/ack/owner got %b expected 0000",
               {bus_rr.busy_o, bus_rr.mem_enable_o, bus_rr.m0_ack_o, bus_rr.owner_o});
    end
    bus_rr.mem_ack_i = 1'b0;
    bus_rr.m1_enable_i = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({bus_rr.busy_o, bus_rr.owner_o} !== 2'b10) begin
      tests_failed++;
      $display("FAIL arst_tie: busy/owner got %b expected 10", {bus_rr.busy_o, bus_rr.owner_o});
    end
    bus_rr.mem_ack_i = 1'b1;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic test_timeout();
    apply_reset();
    bus_rr.m0_enable_i = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      tests_run++;
      if ({bus_rr.busy_o, bus_rr.err_timeout_o} !== 2'b10) begin
        tests_failed++;
        $display("FAIL timeout_wait%0d: busy/err got %b expected 10", i,
                 {bus_rr.busy_o, bus_rr.err_timeout_o});
      end
    end
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({bus_rr.busy_o, bus_rr.err_timeout_o, bus_rr.m0_ack_o} !== 3'b010) begin
      tests_failed++;
      $display("FAIL timeout_fire: busy/err/ack got %b expected 010",
               {bus_rr.busy_o, bus_rr.err_timeout_o, bus_rr.m0_ack_o});
    end
    bus_rr.m0_enable_i = 1'b0; bus_rr.m1_enable_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({bus_rr.busy_o, bus_rr.owner_o, bus_rr.err_timeout_o} !== 3'b111) begin
      tests_failed++;
      $display("FAIL timeout_next: busy/owner/err got %b expected 111",
               {bus_rr.busy_o, bus_rr.owner_o, bus_rr.err_timeout_o});
    end
    bus_rr.mem_ack_i = 1'b1;
    @(posedge clk); #1;
`else
    repeat (20) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({bus_rr.busy_o, bus_rr.mem_enable_o, bus_rr.err_timeout_o} !== 3'b110) begin
      tests_failed++;
      $display("FAIL no_watchdog: busy/en/err got %b expected 110",
               {bus_rr.busy_o, bus_rr.mem_enable_o, bus_rr.err_timeout_o});
    end
`endif
    idle_inputs();
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (bus_rr.busy_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_end_idle: busy got %b expected 0", bus_rr.busy_o);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_fixed_priority();
    test_pending_request();
    test_abort();
    test_async_reset();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion before 200000");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 256-bit Data_Memory port between two line-fill/write-back requesters: port 0 = dcache, port 1 = icache or prefetcher.
- Sits between the cache controllers and Data_Memory.
- Owns the grant until the downstream ack, then routes ack and read data back to the owner only.
- Registered single-owner FSM with selectable fixed or round-robin priority.

Parameters:
ADDR_W, 32, address width
LINE_W, 256, cache line / memory data width
RR_EN_DEFAULT, 1, 1 = round-robin arbitration, 0 = fixed priority (port 0 always wins ties)
TIMEOUT_CYCLES, 64, watchdog limit in cycles; used only with the optional feature

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; asynchronous, active-high
m0_enable_i  in  1  port 0 request; held high until m0_ack_o
m0_write_i  in  1  port 0 1 = write line, 0 = read line
m0_addr_i  in  ADDR_W  port 0 line address
m0_data_i  in  LINE_W  port 0 write data
m0_ack_o  out  1  port 0 completion pulse
m0_data_o  out  LINE_W  port 0 read data; valid with m0_ack_o
m1_enable_i, m1_write_i, m1_addr_i, m1_data_i, m1_ack_o, m1_data_o  same as port 0, for port 1
mem_enable_o  out  1  to Data_Memory enable_i
mem_write_o  out  1  to Data_Memory write_i
mem_addr_o  out  ADDR_W  to Data_Memory addr_i
mem_data_o  out  LINE_W  to Data_Memory data_i
mem_ack_i  in  1  from Data_Memory ack_o
mem_data_i  in  LINE_W  from Data_Memory data_o
busy_o  out  1  transaction in flight
owner_o  out  1  current/last granted port
err_timeout_o  out  1  sticky watchdog flag

Behaviour:
- States:
  - IDLE: no owner.
  - BUSY: owner register valid.
- Reset (async, rst_i=1):
  - state=IDLE, owner=0, last_owner=1 (port 0 wins first tie), err_timeout_o=0.
  - All outputs 0.
- IDLE, at posedge:
  - Exactly one enable high → latch that port as owner, go BUSY.
  - Both high, RR_EN_DEFAULT=1 → grant the port != last_owner.
  - Both high, RR_EN_DEFAULT=0 → grant port 0.
  - Neither high → stay IDLE.
- Arbitration latency: request seen at edge N; mem_enable_o high from cycle N+1.
- BUSY outputs (combinational from owner register):
  - mem_enable_o = owner's enable_i.
  - mem_write_o, mem_addr_o, mem_data_o = owner's signals.
- Outside BUSY: all mem_* outputs are 0.
- Ack routing:
  - mX_ack_o = mem_ack_i & BUSY & (owner==X). The non-owner never sees an ack.
  - m0_data_o and m1_data_o = mem_data_i, broadcast; meaningful only with the matching ack.
- BUSY with mem_ack_i=1 at posedge:
  - last_owner=owner, go IDLE.
  - Guarantees ≥1 cycle with mem_enable_o=0 between transactions, so Data_Memory returns to idle.
- Abort: owner's enable_i low in BUSY without ack → go IDLE next edge; no ack forwarded; last_owner unchanged.
- mem_ack_i while IDLE is ignored.
- Non-owner request during BUSY:
  - Held pending, no effect on the in-flight transaction.
  - Arbitrated in the first IDLE cycle after completion.
- busy_o = (state==BUSY). owner_o = owner register.
- Requesters must keep addr/write/data stable while enable is high; the arbiter does not re-sample them.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined:
  - Counter clears on entry to BUSY and increments each BUSY cycle.
  - Reaching TIMEOUT_CYCLES without mem_ack_i: err_timeout_o set (sticky until rst_i), state forced to IDLE, no ack to the owner, last_owner=owner.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- Undefined: no counter; err_timeout_o tied 0; BUSY waits indefinitely for ack.

Test Plan:
- Port 0 read of addr 0x0000, memory ack after 10 cycles:
  - mem_enable_o rises 1 cycle after the request and stays high 10 cycles.
  - m0_ack_o pulses once with line 0x0000_1111…FFFF; m1_ack_o stays 0.
  - mem_enable_o low the following cycle.
- Both ports request simultaneously, RR_EN_DEFAULT=1, four back-to-back requests each:
  - Grant order 0,1,0,1,0,1,0,1.
  - With RR_EN_DEFAULT=0, all port 0 requests are served before any port 1 request.
- Port 1 requests 3 cycles into a port 0 write of addr 0x0200:
  - Port 1 signals never appear on mem_* during the port 0 transaction.
  - Port 1 is granted the cycle after IDLE following m0_ack_o.
- Port 0 drops enable mid-BUSY with no ack: next cycle IDLE, busy_o=0, no ack pulse.
- rst_i asserted mid-transaction, asynchronously between edges:
  - busy_o, mem_enable_o and acks drop immediately.
  - After release, a tie grants port 0.
- With MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, memory never acks:
  - err_timeout_o rises after 8 BUSY cycles and stays high; arbiter returns to IDLE.
  - A subsequent port 1 request is granted normally.
